// File: rtl/matmul_ctrl.sv
// -----------------------------------------------------------------------------
// matmul_ctrl
//
// Sequencer for a 3x3 MAC-array matrix multiplier. Buffers W (row_w x col_w)
// then X (row_x x col_x) from a valid/ready operand stream, clears the MAC
// accumulators, then drives one inner-product step per cycle onto the three
// W buses and three X buses with a per-MAC load mask. The array's outputs are
// valid when done pulses.
//
// Optional feature: define MATMUL_CTRL_DIMCHECK_EN to reject illegal
// dimensions at start (any zero, or col_w != row_x) with a one-cycle err
// pulse. Without it, err is tied low and the ERR state does not exist.
//
// Ports:
//   clk                         rising-edge clock
//   clear                       synchronous active-high reset, aborts a job
//   start                       one-cycle request, dimensions sampled with it
//   row_w, col_w, row_x, col_x  matrix dimensions (legal 1..3)
//   in_data / in_valid          operand stream
//   in_ready                    high while loading W or X
//   op_w                        W bus r at [r*DW +: DW]
//   op_x                        X bus c at [c*DW +: DW]
//   mac_load                    bit r*3+c: MAC(r,c) accumulates op_w[r]*op_x[c]
//   mac_clear                   clears all MAC accumulators
//   busy                        high in every state except IDLE
//   done                        one-cycle pulse, results stable on the array
//   err                         one-cycle pulse on a dimension error
// All outputs are registered.
// -----------------------------------------------------------------------------
module matmul_ctrl #(
  parameter int DW = 4,
  parameter int N  = 3
) (
  input  logic            clk,
  input  logic            clear,
  input  logic            start,
  input  logic [1:0]      row_w,
  input  logic [1:0]      col_w,
  input  logic [1:0]      row_x,
  input  logic [1:0]      col_x,
  input  logic [DW-1:0]   in_data,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [N*DW-1:0] op_w,
  output logic [N*DW-1:0] op_x,
  output logic [N*N-1:0]  mac_load,
  output logic            mac_clear,
  output logic            busy,
  output logic            done,
  output logic            err
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    LOAD_X,
    CLR,
    MAC,
    DRAIN,
    DONE
`ifdef MATMUL_CTRL_DIMCHECK_EN
    , ERR
`endif
  } state_t;

  // Flat buffer index for (row, col) in a row-major N x N layout.
  function automatic logic [3:0] idx(input logic [1:0] r, input logic [1:0] c);
    return 4'(r) * 4'd3 + 4'(c);
  endfunction

  state_t              state_q, state_d;
  logic [1:0]          rw_q, rw_d, cw_q, cw_d, rx_q, rx_d, cx_q, cx_d;
  logic [1:0]          row_q, row_d, col_q, col_d;   // load walker position
  logic [1:0]          step_q, step_d;               // inner-product step k
  logic                in_ready_q, in_ready_d;
  logic [N*DW-1:0]     op_w_q, op_w_d, op_x_q, op_x_d;
  logic [N*N-1:0]      mac_load_q, mac_load_d;
  logic                mac_clear_q, mac_clear_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
`ifdef MATMUL_CTRL_DIMCHECK_EN
  logic                err_q, err_d;
`endif
  logic [DW-1:0]       wbuf_q [N*N];
  logic [DW-1:0]       wbuf_d [N*N];
  logic [DW-1:0]       xbuf_q [N*N];
  logic [DW-1:0]       xbuf_d [N*N];

  // Load-walker helpers, shared by the W and X phases.
  logic       accept;
  logic [1:0] dim_r, dim_c;
  logic       empty, last_col, last_beat;

  always_comb begin
    // NOTE: every signal gets a default first, so no path can infer a latch.
    state_d     = state_q;
    rw_d        = rw_q;
    cw_d        = cw_q;
    rx_d        = rx_q;
    cx_d        = cx_q;
    row_d       = row_q;
    col_d       = col_q;
    step_d      = step_q;
    wbuf_d      = wbuf_q;
    xbuf_d      = xbuf_q;

    accept    = in_valid && in_ready_q;
    dim_r     = (state_q == LOAD_X) ? rx_q : rw_q;
    dim_c     = (state_q == LOAD_X) ? cx_q : cw_q;
    // A zero dimension means no beats; the phase is skipped after one cycle.
    empty     = (dim_r == 2'd0) || (dim_c == 2'd0);
    last_col  = (col_q == dim_c - 2'd1);
    last_beat = last_col && (row_q == dim_r - 2'd1);

    unique case (state_q)
      IDLE: begin
        if (start) begin
          rw_d  = row_w;
          cw_d  = col_w;
          rx_d  = row_x;
          cx_d  = col_x;
          row_d = '0;
          col_d = '0;
`ifdef MATMUL_CTRL_DIMCHECK_EN
          if (row_w == 2'd0 || col_w == 2'd0 || row_x == 2'd0 ||
              col_x == 2'd0 || col_w != row_x)
            state_d = ERR;
          else
            state_d = LOAD_W;
`else
          state_d = LOAD_W;
`endif
        end
      end

      LOAD_W, LOAD_X: begin
        if (empty || (accept && last_beat)) begin
          row_d = '0;
          col_d = '0;
          if (state_q == LOAD_W) state_d = LOAD_X;
          else                   state_d = CLR;
        end else if (accept) begin
          if (last_col) begin
            col_d = '0;
            row_d = row_q + 2'd1;
          end else begin
            col_d = col_q + 2'd1;
          end
        end
        // The buffer write uses the current walker position in both cases.
        if (!empty && accept) begin
          if (state_q == LOAD_W) wbuf_d[idx(row_q, col_q)] = in_data;
          else                   xbuf_d[idx(row_q, col_q)] = in_data;
        end
      end

      CLR: begin
        state_d = MAC;
        step_d  = '0;
      end

      MAC: begin
        // col_w == 0 is only reachable without the dimension check; a single
        // step keeps the FSM moving towards DONE.
        if (cw_q == 2'd0 || step_q == cw_q - 2'd1) state_d = DRAIN;
        else                                       step_d  = step_q + 2'd1;
      end

      DRAIN: state_d = DONE;
      DONE:  state_d = IDLE;
`ifdef MATMUL_CTRL_DIMCHECK_EN
      ERR:   state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they come straight off flops.
    in_ready_d  = (state_d == LOAD_W) || (state_d == LOAD_X);
    busy_d      = (state_d != IDLE);
    mac_clear_d = (state_d == CLR);
    done_d      = (state_d == DONE);
`ifdef MATMUL_CTRL_DIMCHECK_EN
    err_d       = (state_d == ERR);
`endif
    op_w_d      = '0;
    op_x_d      = '0;
    mac_load_d  = '0;
    if (state_d == MAC) begin
      for (int r = 0; r < N; r++) begin
        if (r < int'(rw_q)) op_w_d[r*DW +: DW] = wbuf_q[idx(2'(r), step_d)];
      end
      for (int c = 0; c < N; c++) begin
        if (c < int'(cx_q)) op_x_d[c*DW +: DW] = xbuf_q[idx(step_d, 2'(c))];
      end
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          mac_load_d[r*N + c] = (r < int'(rw_q)) && (c < int'(cx_q));
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of the others.
  always_ff @(posedge clk) begin
    if (clear) begin
      state_q     <= IDLE;
      rw_q        <= '0;
      cw_q        <= '0;
      rx_q        <= '0;
      cx_q        <= '0;
      row_q       <= '0;
      col_q       <= '0;
      step_q      <= '0;
      in_ready_q  <= 1'b0;
      op_w_q      <= '0;
      op_x_q      <= '0;
      mac_load_q  <= '0;
      mac_clear_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef MATMUL_CTRL_DIMCHECK_EN
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rw_q        <= rw_d;
      cw_q        <= cw_d;
      rx_q        <= rx_d;
      cx_q        <= cx_d;
      row_q       <= row_d;
      col_q       <= col_d;
      step_q      <= step_d;
      in_ready_q  <= in_ready_d;
      op_w_q      <= op_w_d;
      op_x_q      <= op_x_d;
      mac_load_q  <= mac_load_d;
      mac_clear_q <= mac_clear_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef MATMUL_CTRL_DIMCHECK_EN
      err_q       <= err_d;
`endif
    end
  end

  // NOTE: the operand buffers have no reset; every read is masked by the
  // latched dimensions, so stale entries are never observed.
  always_ff @(posedge clk) begin
    wbuf_q <= wbuf_d;
    xbuf_q <= xbuf_d;
  end

  assign in_ready  = in_ready_q;
  assign op_w      = op_w_q;
  assign op_x      = op_x_q;
  assign mac_load  = mac_load_q;
  assign mac_clear = mac_clear_q;
  assign busy      = busy_q;
  assign done      = done_q;
`ifdef MATMUL_CTRL_DIMCHECK_EN
  assign err       = err_q;
`else
  assign err       = 1'b0;
`endif

endmodule

// File: doc/matmul_ctrl.md
# matmul_ctrl

Sequencer for the 3x3 MAC-array matrix multiplier. Accepts a 4-bit operand stream on a valid/ready handshake and buffers matrix W (row_w x col_w) followed by matrix X (row_x x col_x), both row-major. It then clears the nine MAC accumulators and drives one inner-product step per cycle onto the array's three W buses and three X buses, with a per-MAC load mask. Sits between the operand source and the MAC array; the array's o11..o33 outputs are valid when `done` pulses.

## Interface
Parameters:
- DW, 4, operand width (data_in and each operand bus)
- N, 3, array edge; fixed at 3, all buffers are sized N*N

Ports:
- clk  in  1  rising-edge clock
- clear  in  1  reset, synchronous, active-high
- start  in  1  one-cycle request; dimensions are sampled on the same cycle
- row_w, col_w, row_x, col_x  in  2 each  matrix dimensions; legal range 1..3
- in_data  in  DW  operand stream
- in_valid  in  1  in_data valid
- in_ready  out  1  high in LOAD_W/LOAD_X; a beat transfers when in_valid && in_ready
- op_w  out  3*DW  W bus r at bits [r*DW +: DW], r=0..2
- op_x  out  3*DW  X bus c at bits [c*DW +: DW], c=0..2
- mac_load  out  9  bit r*3+c enables MAC(r,c) to accumulate op_w[r]*op_x[c]
- mac_clear  out  1  synchronous clear for all MAC accumulators
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse; results are stable on the array
- err  out  1  one-cycle pulse; dimension error

## Operation
- States: IDLE, LOAD_W, LOAD_X, CLR, MAC, DRAIN, DONE, ERR.
- IDLE: start=1 latches all dimensions. If `MATMUL_CTRL_DIMCHECK_EN` is defined and the dimensions are illegal, go to ERR; otherwise go to LOAD_W. start is ignored in every other state.
- LOAD_W: each accepted beat is written to wbuf[r*3+k] in row-major order over row_w x col_w. After the last beat, go to LOAD_X.
- LOAD_X: each accepted beat is written to xbuf[k*3+c] over row_x x col_x. After the last beat, go to CLR.
- CLR: mac_clear=1 for one cycle, then go to MAC with step k=0.
- MAC: for step k (0..col_w-1):
  - op_w bus r = wbuf[r*3+k] if r<row_w, else 0.
  - op_x bus c = xbuf[k*3+c] if c<col_x, else 0.
  - mac_load[r*3+c] = (r<row_w && c<col_x).
  - After step col_w-1, go to DRAIN.
- DRAIN: operands are 0 and mac_load=0 for one cycle, so the array registers the final step.
- DONE: done=1 for one cycle, then go to IDLE.
- ERR: err=1 for one cycle, then go to IDLE.
- Arithmetic is done in the MACs (10-bit accumulators). The worst case is 3*15*15=675, so no overflow is possible.
- The buffers are not cleared on reset. Stale entries are never used, because all indexing is masked by the latched dimensions.

## Timing
- All outputs are registered.
- Reset values: in_ready=0, op_w=0, op_x=0, mac_load=0, mac_clear=0, busy=0, done=0, err=0, state=IDLE.
- start in cycle t: busy=1 and in_ready=1 from t+1.
- Total latency from start to done: 1 + (row_w*col_w + row_x*col_x accepted beats, plus any in_valid stalls) + 1 CLR + col_w MAC + 1 DRAIN, with done high on the following cycle.
- A 3x3 x 3x3 job with no stalls has done at t+1+18+1+3+1 = t+24.
- in_valid low stalls the load with no data loss. in_ready drops on the cycle after the last beat of X.
- clear asserted in any state forces the reset values on the next edge, aborting the job. The MAC array's own accumulators are reset by the parent.
- done and err never assert in the same cycle.

## Configuration
- `MATMUL_CTRL_DIMCHECK_EN` defined:
  - At start, any dimension equal to 0, or col_w != row_x, sends the FSM to ERR: err pulses one cycle after start, and busy is high for exactly that one cycle.
- Not defined:
  - The ERR state is not present and err is tied to 0.
  - The step count uses col_w.
  - Zero dimensions produce undefined results, but the FSM still reaches DONE.

## Test plan
- Reset and idle: clear high for 2 cycles -> all outputs 0; in_ready=0 while in_valid is held high.
- 2x2: W=[1,2;3,4], X=[5,6;7,8], no stalls -> mac_load=9'b000_011_011 for 2 MAC cycles; done at t+13; array outputs o11=19, o12=22, o21=43, o22=50, all unused MACs 0.
- 3x3 all-15, with in_valid low on every 3rd cycle -> no beats lost; done after the stalls plus 24 cycles; all nine outputs 675.
- 3x2 times 2x1: W=[1,2;3,4;5,6], X=[1;1] -> only mac_load bits 0, 3, 6 are set; outputs 3, 7, 11; two MAC cycles.
- Dimension error (DIMCHECK_EN): start with col_w=2, row_x=3 -> err=1 at t+1, in_ready never high, back in IDLE at t+2. Without the macro, the FSM reaches DONE.
- Abort: clear in the 2nd MAC cycle -> next cycle all outputs 0 and state IDLE; a following start completes correctly with no state carried over from the aborted job.
